// File: rtl/count_16_bit_pkg.sv
// Shared constants, types and the parity helper for the 16-bit population counter.
package count_16_bit_pkg;

  localparam int DATA_W      = 32'd16;
  localparam int COUNT_W     = 32'd5;
  localparam int NIBBLE_W    = 32'd4;
  localparam int NUM_NIBBLES = 32'd4;

  typedef logic [2:0]         nib_cnt_t;
  typedef logic [COUNT_W:1]   count_t;

  function automatic logic parity16(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/count_4_bit.sv
// Combinational popcount of one 4-bit nibble (result 0..4).
module count_4_bit
  import count_16_bit_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nib_i,
  output nib_cnt_t            cnt_o
);

  assign cnt_o = {2'b00, nib_i[0]} + {2'b00, nib_i[1]}
               + {2'b00, nib_i[2]} + {2'b00, nib_i[3]};

endmodule

// File: rtl/count_16_bit_pop.sv
// Two-stage pipelined popcount of a 16-bit word; one result per cycle, no backpressure.
// Optional PARITY output is built when the COUNT_PARITY_EN macro is defined.
module count_16_bit_pop
  import count_16_bit_pkg::*;
#(
  parameter int DATA_W = count_16_bit_pkg::DATA_W
)
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] INPUT_DATA,
  output logic              OUT_VALID,
  output count_t            COUNT
`ifdef COUNT_PARITY_EN
  ,
  output logic              PARITY
`endif
);

  if (DATA_W != 32'd16) begin : g_bad_data_w
    $error("count_16_bit_pop: only DATA_W=16 is supported");
  end

  nib_cnt_t nib_cnt_s [NUM_NIBBLES];
  nib_cnt_t nib_d     [NUM_NIBBLES];
  nib_cnt_t nib_q     [NUM_NIBBLES];
  logic     vld1_d, vld1_q;
  logic     out_valid_d, out_valid_q;
  count_t   sum_s;
  count_t   count_d, count_q;

  for (genvar g = 0; g < NUM_NIBBLES; g++) begin : g_nib
    count_4_bit u_count_4_bit (
      .nib_i (INPUT_DATA[g*NIBBLE_W +: NIBBLE_W]),
      .cnt_o (nib_cnt_s[g])
    );
  end

  // Adder tree for stage 2: four zero-extended nibble counts, max 16 fits in 5 bits.
  always_comb begin
    sum_s = 5'd0;
    for (int i = 0; i < NUM_NIBBLES; i++) begin
      sum_s = sum_s + {2'b00, nib_q[i]};
    end
  end

  // Next-state: stage 1 only loads on valid so idle X data never reaches COUNT.
  always_comb begin
    nib_d       = nib_q;
    vld1_d      = IN_VALID;
    out_valid_d = vld1_q;
    count_d     = count_q;
    if (IN_VALID) begin
      nib_d = nib_cnt_s;
    end else begin
      nib_d = nib_q;
    end
    if (vld1_q) begin
      count_d = sum_s;
    end else begin
      count_d = count_q;
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_NIBBLES; i++) begin
        nib_q[i] <= 3'd0;
      end
      vld1_q      <= 1'b0;
      out_valid_q <= 1'b0;
      count_q     <= 5'd0;
    end else begin
      nib_q       <= nib_d;
      vld1_q      <= vld1_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign COUNT     = count_q;

`ifdef COUNT_PARITY_EN
  logic par1_d, par1_q;
  logic par2_d, par2_q;

  // Parity follows the same load/hold rules as the count it accompanies.
  always_comb begin
    par1_d = par1_q;
    par2_d = par2_q;
    if (IN_VALID) begin
      par1_d = parity16(INPUT_DATA);
    end else begin
      par1_d = par1_q;
    end
    if (vld1_q) begin
      par2_d = par1_q;
    end else begin
      par2_d = par2_q;
    end
  end

  // Parity pipeline registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      par1_q <= 1'b0;
      par2_q <= 1'b0;
    end else begin
      par1_q <= par1_d;
      par2_q <= par2_d;
    end
  end

  assign PARITY = par2_q;
`endif

endmodule

// File: tb/tb_count_16_bit_pop.sv
// Self-checking bench: directed plan steps followed by random traffic against a $countones model.
module tb_count_16_bit_pop;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic [5:1]  count;
`ifdef COUNT_PARITY_EN
  logic        parity;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Model state: what was applied on the previous edge and the currently expected outputs.
  logic        prev_r = 1'b1;
  logic        prev_v = 1'b0;
  logic [15:0] prev_d = 16'h0000;
  logic        exp_v;
  logic [4:0]  exp_cnt = 5'd0;
  logic        exp_par = 1'b0;

  always #5 clk = ~clk;

  count_16_bit_pop dut (
    .CLK        (clk),
    .RST        (rst),
    .IN_VALID   (in_valid),
    .INPUT_DATA (in_data),
    .OUT_VALID  (out_valid),
    .COUNT      (count)
`ifdef COUNT_PARITY_EN
    ,
    .PARITY     (parity)
`endif
  );

  // Apply one cycle of inputs, advance the model, and compare after the edge.
  task automatic step(input logic r, input logic v, input logic [15:0] d);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    // A word sampled on edge k appears after edge k+1 unless either edge had reset.
    exp_v = !r && !prev_r && prev_v;
    if (r) begin
      exp_cnt = 5'd0;
      exp_par = 1'b0;
    end else if (exp_v) begin
      exp_cnt = 5'($countones(prev_d));
      exp_par = ^prev_d;
    end
    n_vec++;
    assert (out_valid === exp_v)
      else begin n_err++; $error("FAIL out_valid: observed %b expected %b (t=%0t)", out_valid, exp_v, $time); end
    n_vec++;
    assert (count === exp_cnt)
      else begin n_err++; $error("FAIL count: observed %0d expected %0d (t=%0t)", count, exp_cnt, $time); end
`ifdef COUNT_PARITY_EN
    n_vec++;
    assert (parity === exp_par)
      else begin n_err++; $error("FAIL parity: observed %b expected %b (t=%0t)", parity, exp_par, $time); end
`endif
    prev_r = r;
    prev_v = v;
    prev_d = d;
  endtask

  initial begin
    logic        r, v;
    logic [15:0] d;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 16'h0000;

    // Reset then idle
    step(1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'hxxxx);

    // Single word
    step(1'b0, 1'b1, 16'h7FFF);
    step(1'b0, 1'b0, 16'hxxxx);
    step(1'b0, 1'b0, 16'hxxxx);
    step(1'b0, 1'b0, 16'h0000);

    // Extremes back-to-back
    step(1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b1, 16'hFFFF);
    step(1'b0, 1'b1, 16'h8001);
    step(1'b0, 1'b0, 16'hxxxx);
    step(1'b0, 1'b0, 16'hxxxx);
    step(1'b0, 1'b0, 16'hxxxx);

    // Bubble
    step(1'b0, 1'b1, 16'h00FF);
    step(1'b0, 1'b0, 16'hxxxx);
    step(1'b0, 1'b1, 16'hAAAA);
    step(1'b0, 1'b0, 16'hxxxx);
    step(1'b0, 1'b0, 16'hxxxx);
    step(1'b0, 1'b0, 16'hxxxx);

    // Mid-operation reset, including a valid word on the reset edge
    step(1'b0, 1'b1, 16'h0F0F);
    step(1'b1, 1'b1, 16'hFFFF);
    step(1'b0, 1'b0, 16'hxxxx);
    step(1'b0, 1'b0, 16'hxxxx);

    // Parity pair
    step(1'b0, 1'b1, 16'h0007);
    step(1'b0, 1'b1, 16'h0003);
    step(1'b0, 1'b0, 16'hxxxx);
    step(1'b0, 1'b0, 16'hxxxx);
    step(1'b0, 1'b0, 16'hxxxx);

    // Random traffic with occasional resets, extremes and X on idle data
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 31) == 0);
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       d = 16'h0000;
        1:       d = 16'hFFFF;
        default: d = 16'($urandom);
      endcase
      if (!v && $urandom_range(0, 1) == 1) d = 16'hxxxx;
      step(r, v, d);
    end
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
